// File: rtl/snake_body_ctrl.sv
// Snake movement/draw sequencer: body-RAM init, per-tick shift, tail erase, head plot, growth.
// Optional macro SNAKE_REDRAW_EN adds a full-body re-plot after the head tile.
module snake_body_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int MAX_LEN   = 1024,
    parameter int INIT_LEN  = 3,
    parameter int TILE_CYC  = 16,
    parameter int GROW_STEP = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,          // synchronous, active low
    input  logic              from_black_i,
    input  logic              go_i,
    input  logic              grow_i,
    input  logic              is_dead_i,
    input  logic [2:0]        colour_in_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic              ld_def_o,
    output logic              ld_head_prev_o,
    output logic              ld_curr_o,
    output logic              ld_curr_prev_o,
    output logic              update_head_o,
    output logic              draw_en_o,
    output logic [1:0]        draw_sel_o,
    output logic [3:0]        draw_cnt_o,
    output logic [2:0]        colour_out_o,
    output logic [ADDR_W:0]   length_o,
    output logic              busy_o,
    output logic [4:0]        state_o
);
    typedef enum logic [4:0] {
        S_IDLE, S_INIT, S_WAIT, S_ER_RD, S_ER_CAP, S_ER_DRAW, S_HPREV,
        S_SH_RD, S_SH_CAP, S_SH_WR, S_SH_ADV, S_EXT, S_HEAD, S_DHEAD,
        S_DFOOD, S_RD_RD, S_RD_CAP, S_RD_DRAW
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] mem_addr;
        logic              mem_rd;
        logic              mem_wr;
        logic              ld_def;
        logic              ld_head_prev;
        logic              ld_curr;
        logic              ld_curr_prev;
        logic              update_head;
        logic              draw_en;
        logic [1:0]        draw_sel;
        logic [3:0]        draw_cnt;
        logic [2:0]        colour;
        logic              busy;
    } out_t;

    localparam logic [ADDR_W:0]   LEN_INIT = (ADDR_W+1)'(INIT_LEN);
    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0]   STEP     = (ADDR_W+1)'(GROW_STEP);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [3:0]        PIX_LAST = 4'(TILE_CYC - 1);

    state_t            state_q, state_d, food_next;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        pix_q, pix_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic              grow_pend_q, grow_pend_d;
    logic              grow_seen_q, grow_seen_d;
    logic              tick_grow_q, tick_grow_d;
    out_t              out_q, out_d;
    logic [ADDR_W:0]   room, ext_n;
    logic              last_seg, pix_last;

    // Growth is clipped so the body never exceeds MAX_LEN segments.
    assign room     = LEN_MAX - length_q;
    assign ext_n    = (room < STEP) ? room : STEP;
    assign last_seg = ({1'b0, idx_q} == length_q - LEN_ONE);
    assign pix_last = (pix_q == PIX_LAST);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pix_d       = pix_q;
        length_d    = length_q;
        grow_pend_d = grow_pend_q | grow_i;
        tick_grow_d = tick_grow_q;
        grow_seen_d = grow_seen_q;
        if (!(state_q inside {S_IDLE, S_INIT, S_WAIT}) && grow_i)
            grow_seen_d = 1'b1;
        food_next = grow_seen_d ? S_DFOOD : S_WAIT;
        case (state_q)
            S_IDLE:    if (from_black_i) begin state_d = S_INIT; idx_d = '0; end
            S_INIT: begin
                if ({1'b0, idx_q} == LEN_INIT - LEN_ONE) begin
                    state_d = S_WAIT; idx_d = '0; length_d = LEN_INIT; grow_pend_d = 1'b0;
                end else idx_d = idx_q + IDX_ONE;
            end
            // A pending grow keeps the tail: skip the erase and extend after the shift.
            S_WAIT: if (go_i) begin
                tick_grow_d = grow_pend_q;
                grow_pend_d = grow_i;
                grow_seen_d = grow_i;
                state_d     = grow_pend_q ? S_HPREV : S_ER_RD;
            end
            S_ER_RD:   state_d = S_ER_CAP;
            S_ER_CAP:  begin state_d = S_ER_DRAW; pix_d = '0; end
            S_ER_DRAW: if (pix_last) state_d = S_HPREV; else pix_d = pix_q + 4'd1;
            S_HPREV:   begin state_d = S_SH_RD; idx_d = '0; end
            S_SH_RD:   state_d = S_SH_CAP;
            S_SH_CAP:  state_d = S_SH_WR;
            S_SH_WR:   state_d = S_SH_ADV;
            S_SH_ADV: begin
                if (last_seg) begin
                    idx_d   = '0;
                    state_d = tick_grow_q ? S_EXT : S_HEAD;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_SH_RD;
                end
            end
            S_EXT: begin
                if (ext_n == '0 || {1'b0, idx_q} == ext_n - LEN_ONE) begin
                    length_d = length_q + ext_n; tick_grow_d = 1'b0; idx_d = '0; state_d = S_HEAD;
                end else idx_d = idx_q + IDX_ONE;
            end
            S_HEAD:    begin state_d = S_DHEAD; pix_d = '0; end
            S_DHEAD: begin
                if (pix_last) begin
                    pix_d = '0;
`ifdef SNAKE_REDRAW_EN
                    if (length_q > LEN_ONE) begin state_d = S_RD_RD; idx_d = IDX_ONE; end
                    else state_d = food_next;
`else
                    state_d = food_next;
`endif
                end else pix_d = pix_q + 4'd1;
            end
            S_RD_RD:   state_d = S_RD_CAP;
            S_RD_CAP:  begin state_d = S_RD_DRAW; pix_d = '0; end
            S_RD_DRAW: begin
                if (pix_last) begin
                    pix_d = '0;
                    if (last_seg) state_d = food_next;
                    else begin idx_d = idx_q + IDX_ONE; state_d = S_RD_RD; end
                end else pix_d = pix_q + 4'd1;
            end
            S_DFOOD:   if (pix_last) state_d = S_WAIT; else pix_d = pix_q + 4'd1;
            default:   state_d = S_IDLE;
        endcase
        if (is_dead_i) begin
            state_d = S_IDLE; idx_d = '0; pix_d = '0;
            grow_pend_d = 1'b0; grow_seen_d = 1'b0; tick_grow_d = 1'b0;
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        out_d      = '0;
        out_d.busy = 1'b1;
        case (state_d)
            S_IDLE, S_WAIT: out_d.busy = 1'b0;
            S_INIT:    begin out_d.mem_addr = idx_d; out_d.ld_def = 1'b1; out_d.mem_wr = 1'b1; end
            S_ER_RD:   begin out_d.mem_addr = ADDR_W'(length_d - LEN_ONE); out_d.mem_rd = 1'b1; end
            S_ER_CAP:  begin out_d.mem_addr = ADDR_W'(length_d - LEN_ONE); out_d.ld_curr = 1'b1; end
            S_ER_DRAW: begin out_d.draw_en = 1'b1; out_d.draw_sel = 2'd0; out_d.draw_cnt = pix_d; end
            S_HPREV:   out_d.ld_head_prev = 1'b1;
            S_SH_RD:   begin out_d.mem_addr = idx_d; out_d.mem_rd = 1'b1; end
            S_SH_CAP:  begin out_d.mem_addr = idx_d; out_d.ld_curr = 1'b1; end
            S_SH_WR:   begin out_d.mem_addr = idx_d; out_d.mem_wr = 1'b1; end
            S_SH_ADV:  begin out_d.mem_addr = idx_d; out_d.ld_curr_prev = 1'b1; end
            S_EXT:     begin
                out_d.mem_addr = ADDR_W'(length_d + {1'b0, idx_d});
                out_d.mem_wr   = (ext_n != '0);
            end
            S_HEAD:    out_d.update_head = 1'b1;
            S_DHEAD:   begin
                out_d.draw_en = 1'b1; out_d.draw_sel = 2'd1; out_d.draw_cnt = pix_d; out_d.colour = 3'b100;
            end
            S_RD_RD:   begin out_d.mem_addr = idx_d; out_d.mem_rd = 1'b1; end
            S_RD_CAP:  begin out_d.mem_addr = idx_d; out_d.ld_curr = 1'b1; end
            S_RD_DRAW: begin
                out_d.draw_en = 1'b1; out_d.draw_sel = 2'd2; out_d.draw_cnt = pix_d; out_d.colour = colour_in_i;
            end
            S_DFOOD:   begin
                out_d.draw_en = 1'b1; out_d.draw_sel = 2'd3; out_d.draw_cnt = pix_d; out_d.colour = 3'b010;
            end
            default:   out_d.busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pix_q       <= '0;
            length_q    <= LEN_INIT;
            grow_pend_q <= 1'b0;
            grow_seen_q <= 1'b0;
            tick_grow_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pix_q       <= pix_d;
            length_q    <= length_d;
            grow_pend_q <= grow_pend_d;
            grow_seen_q <= grow_seen_d;
            tick_grow_q <= tick_grow_d;
            out_q       <= out_d;
        end
    end

    assign mem_addr_o     = out_q.mem_addr;
    assign mem_rd_o       = out_q.mem_rd;
    assign mem_wr_o       = out_q.mem_wr;
    assign ld_def_o       = out_q.ld_def;
    assign ld_head_prev_o = out_q.ld_head_prev;
    assign ld_curr_o      = out_q.ld_curr;
    assign ld_curr_prev_o = out_q.ld_curr_prev;
    assign update_head_o  = out_q.update_head;
    assign draw_en_o      = out_q.draw_en;
    assign draw_sel_o     = out_q.draw_sel;
    assign draw_cnt_o     = out_q.draw_cnt;
    assign colour_out_o   = out_q.colour;
    assign busy_o         = out_q.busy;
    assign length_o       = length_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: a body-datapath model follows the strobes, and the resulting
// RAM/head/length plus draw activity are compared against a list-level model of the snake.
module tb_snake_body_ctrl;
    localparam int ADDR_W    = 4;
    localparam int MAX_LEN   = 6;
    localparam int INIT_LEN  = 3;
    localparam int TILE_CYC  = 16;
    localparam int GROW_STEP = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic from_black = 1'b0, go = 1'b0, grow = 1'b0, is_dead = 1'b0;
    logic [2:0] colour_in = 3'b011;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_rd, mem_wr, ld_def, ld_head_prev, ld_curr, ld_curr_prev, update_head, draw_en, busy;
    logic [1:0] draw_sel;
    logic [3:0] draw_cnt;
    logic [2:0] colour_out;
    logic [ADDR_W:0] length;
    logic [4:0] dbg_state;

    always #5 clk = ~clk;

    snake_body_ctrl #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN),
                      .TILE_CYC(TILE_CYC), .GROW_STEP(GROW_STEP)) dut (
        .clk_i(clk), .rst_i(rst_n), .from_black_i(from_black), .go_i(go), .grow_i(grow),
        .is_dead_i(is_dead), .colour_in_i(colour_in), .mem_addr_o(mem_addr), .mem_rd_o(mem_rd),
        .mem_wr_o(mem_wr), .ld_def_o(ld_def), .ld_head_prev_o(ld_head_prev), .ld_curr_o(ld_curr),
        .ld_curr_prev_o(ld_curr_prev), .update_head_o(update_head), .draw_en_o(draw_en),
        .draw_sel_o(draw_sel), .draw_cnt_o(draw_cnt), .colour_out_o(colour_out),
        .length_o(length), .busy_o(busy), .state_o(dbg_state)
    );

    int n_assert = 0, n_fail = 0;
    // datapath model driven by the strobes
    int ram[16];
    int head, prev, curr, rd_data, dir;
    // list-level reference of the snake
    int exp_body[$];
    int exp_head, exp_len;
    bit exp_pend;
    // per-tick observations
    int cnt_sel[4];
    int draw_err, wr_bad, init_wr, erase_val, wr_limit;
    bit erase_seen, prev_draw;
    logic [1:0] prev_sel;
    int prev_cnt;
    int dirs[4] = '{1, -1, 100, -100};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] sel_colour(input logic [1:0] sel);
        case (sel)
            2'd0:    return 3'b000;
            2'd1:    return 3'b100;
            2'd2:    return colour_in;
            default: return 3'b010;
        endcase
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) cnt_sel[i] = 0;
        draw_err = 0; wr_bad = 0; init_wr = 0; erase_seen = 1'b0; erase_val = -12345;
        prev_draw = 1'b0; prev_sel = 2'd0; prev_cnt = 0;
    endtask

    task automatic step();
        int exp_cnt;
        @(posedge clk); #1;
        if (mem_rd) rd_data = ram[mem_addr];
        if (ld_curr) curr = rd_data;
        if (ld_head_prev) prev = head;
        if (ld_curr_prev) prev = curr;
        if (mem_wr) begin
            if (int'(mem_addr) >= wr_limit) wr_bad++;
            if (ld_def) begin
                ram[mem_addr] = 1000 - int'(mem_addr);
                init_wr++;
                if (mem_addr == 0) head = 1000;
            end else ram[mem_addr] = prev;
        end
        if (update_head) head += dir;
        if (draw_en) begin
            cnt_sel[draw_sel]++;
            if (colour_out !== sel_colour(draw_sel)) draw_err++;
            exp_cnt = (prev_draw && prev_sel == draw_sel && prev_cnt != TILE_CYC - 1) ? prev_cnt + 1 : 0;
            if (int'(draw_cnt) != exp_cnt) draw_err++;
            if (draw_sel == 2'd0 && !erase_seen) begin erase_val = curr; erase_seen = 1'b1; end
        end else if (draw_cnt != 4'd0) draw_err++;
        prev_draw = draw_en; prev_sel = draw_sel; prev_cnt = int'(draw_cnt);
    endtask

    task automatic do_init();
        int cyc, body_err;
        for (int i = 0; i < 16; i++) ram[i] = -1;
        head = -1; clear_stats(); wr_limit = INIT_LEN;
        from_black = 1'b1; step(); from_black = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin cyc++; step(); end
        exp_body = {};
        for (int i = 0; i < INIT_LEN; i++) exp_body.push_back(1000 - i);
        exp_head = 1000; exp_len = INIT_LEN; exp_pend = 1'b0;
        body_err = 0;
        for (int i = 0; i < INIT_LEN; i++) if (ram[i] != exp_body[i]) body_err++;
        chk("init_cycles", cyc, INIT_LEN);
        chk("init_writes", init_wr, INIT_LEN);
        chk("init_length", length, INIT_LEN);
        chk("init_body", body_err, 0);
        chk("init_head", head, 1000);
        chk("init_wr_range", wr_bad, 0);
    endtask

    task automatic grow_in_wait();
        grow = 1'b1; step(); grow = 1'b0;
        exp_pend = 1'b1;
        chk("grow_wait_idle", busy, 0);
    endtask

    task automatic do_tick(input bit grow_mid, input bit go_mid);
        int len0, n, nl, lat, cyc, grow_at, tail, body_err;
        bit pend;
        len0 = exp_len; pend = exp_pend;
        n  = pend ? ((MAX_LEN - len0) < GROW_STEP ? MAX_LEN - len0 : GROW_STEP) : 0;
        nl = len0 + n;
        lat = pend ? (1 + 4 * len0 + (n > 0 ? n : 1) + 1 + TILE_CYC)
                   : (2 + TILE_CYC + 1 + 4 * len0 + 1 + TILE_CYC);
`ifdef SNAKE_REDRAW_EN
        lat += (nl - 1) * (2 + TILE_CYC);
`endif
        if (grow_mid) lat += TILE_CYC;
        tail = exp_body[len0 - 1];
        grow_at = $urandom_range(10, 1);
        dir = dirs[$urandom_range(3, 0)];
        clear_stats(); wr_limit = nl;
        go = 1'b1; step(); go = 1'b0;
        cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            grow = grow_mid && (cyc == grow_at);
            go   = go_mid && (cyc == 7);
            step();
        end
        grow = 1'b0; go = 1'b0;
        exp_body.push_front(exp_head);
        void'(exp_body.pop_back());
        repeat (n) exp_body.push_back(tail);
        exp_head += dir; exp_len = nl; exp_pend = grow_mid;
        body_err = 0;
        for (int i = 0; i < nl; i++) if (ram[i] != exp_body[i]) body_err++;
        chk("tick_latency", cyc, lat);
        chk("tick_length", length, nl);
        chk("tick_body", body_err, 0);
        chk("tick_head", head, exp_head);
        chk("tick_erase_tiles", cnt_sel[0], pend ? 0 : TILE_CYC);
        chk("tick_head_tiles", cnt_sel[1], TILE_CYC);
`ifdef SNAKE_REDRAW_EN
        chk("tick_body_tiles", cnt_sel[2], (nl - 1) * TILE_CYC);
`else
        chk("tick_body_tiles", cnt_sel[2], 0);
`endif
        chk("tick_food_tiles", cnt_sel[3], grow_mid ? TILE_CYC : 0);
        chk("tick_draw_seq", draw_err, 0);
        chk("tick_wr_range", wr_bad, 0);
        if (!pend) chk("tick_erase_tail", erase_val, tail);
        repeat (3) step();
        chk("tick_go_not_queued", busy, 0);
    endtask

    task automatic do_death();
        int len0, kill_at;
        len0 = exp_len;
        // busy cycles 2+T+1 cover erase and head-prev; 4 more finish segment 0
        kill_at = 2 + TILE_CYC + 1 + 4 + 1 + $urandom_range(3, 0);
        clear_stats(); wr_limit = 16; dir = 1;
        go = 1'b1; step(); go = 1'b0;
        for (int c = 1; c < kill_at; c++) step();
        chk("dead_at_idx1", mem_addr, 1);
        is_dead = 1'b1; grow = 1'b1; step(); is_dead = 1'b0; grow = 1'b0;
        chk("dead_busy", busy, 0);
        chk("dead_strobes", {mem_rd, mem_wr, ld_def, ld_head_prev, ld_curr, ld_curr_prev, update_head, draw_en}, 0);
        chk("dead_length_kept", length, len0);
        go = 1'b1; step(); go = 1'b0; step();
        chk("dead_go_ignored", busy, 0);
        exp_pend = 1'b0;
    endtask

    initial begin
        colour_in = 3'($urandom_range(7, 1));
        clear_stats(); wr_limit = 16;
        rst_n = 1'b0; step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_rd, mem_wr, ld_def, ld_head_prev, ld_curr, ld_curr_prev, update_head, draw_en}, 0);
        chk("rst_length", length, INIT_LEN);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_colour", colour_out, 0);
        chk("rst_draw_cnt", draw_cnt, 0);
        rst_n = 1'b1; step();
        chk("idle_waits_from_black", busy, 0);
        do_init();
        do_tick(1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        do_tick(1'b0, 1'b1);
        grow_in_wait(); do_tick(1'b0, 1'b0);
        grow_in_wait(); do_tick(1'b0, 1'b0);
        chk("saturated_length", length, MAX_LEN);
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(3, 0) == 0) grow_in_wait();
            do_tick(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
        if (exp_pend) do_tick(1'b0, 1'b0);
        do_death();
        do_init();
        do_tick(1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
